// File: rtl/window_stream.sv
// window_stream: streaming window multiplier.
// Each accepted sample is multiplied by a coefficient from a SIZE-entry
// register table. The table is indexed by a per-frame sample counter. The
// product is rounded half-up, saturated to OW bits and sent downstream
// through a two-stage valid/ready pipeline.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   coef_we/coef_addr/coef_wdata   coefficient table write (Q1.(CW-1), unsigned)
//   cfg_bypass                     use 1.0 instead of the table entry
//   s_valid/s_ready/s_data/s_last  input stream (signed samples)
//   m_valid/m_ready/m_data/m_last  output stream (signed samples)
//   frame_err                      one-cycle pulse when a frame ends early
//   sat_flag                       sticky, set when an output saturates
module window_stream #(
  parameter int SIZE = 8,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int OW   = 16,
  localparam int AW  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic [CW-1:0]        coef_wdata,
  input  logic                 cfg_bypass,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  output logic                 m_last,
  output logic                 frame_err,
  output logic                 sat_flag
);

  localparam int PW = DW + CW + 1;
  localparam logic [CW-1:0]        ONE  = {1'b1, {(CW-1){1'b0}}};
  localparam logic signed [PW-1:0] RND  = PW'(1) << (CW-2);
  localparam logic signed [PW-1:0] OMAX = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW-1:0] OMIN = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Round half-up then drop the CW-1 fractional bits of the coefficient.
  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
    round_shift = (p + RND) >>> (CW-1);
  endfunction

  function automatic logic is_sat(input logic signed [PW-1:0] r);
    is_sat = (r > OMAX) || (r < OMIN);
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [PW-1:0] r);
    if (r > OMAX)      saturate = OMAX[OW-1:0];
    else if (r < OMIN) saturate = OMIN[OW-1:0];
    else               saturate = r[OW-1:0];
  endfunction

  logic [CW-1:0]        coef_q [SIZE];
  logic [AW-1:0]        idx_q;
  logic [AW-1:0]        idx_d;
  logic                 idx_at_end;
  logic                 advance;
  logic                 accept;
  logic [CW-1:0]        coef_sel;
  logic signed [CW:0]   coef_s;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] prod_p1;
  logic                 last_p1;
  logic                 vld_p1;
  logic signed [PW-1:0] rnd_p1;

  assign advance    = !m_valid || m_ready;
  assign s_ready    = !vld_p1 || advance;
  assign accept     = s_valid && s_ready;
  assign idx_at_end = (idx_q == AW'(SIZE-1));

  // An early s_last restarts the frame so the next sample uses coef[0].
  assign idx_d = (s_last || idx_at_end) ? '0 : idx_q + AW'(1);

  // The table is a register, so a same-cycle write is seen only by later samples.
  assign coef_sel = cfg_bypass ? ONE : coef_q[idx_q];
  assign coef_s   = {1'b0, coef_sel};
  assign prod_d   = PW'(s_data) * PW'(coef_s);
  assign rnd_p1   = round_shift(prod_p1);

  // Stage 1 product register: data only, qualified by vld_p1.
  always_ff @(posedge clk) begin
    if (accept) prod_p1 <= prod_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) coef_q[i] <= ONE;
      idx_q     <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      frame_err <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      if (coef_we && (int'(coef_addr) < SIZE)) coef_q[coef_addr] <= coef_wdata;

      frame_err <= accept && s_last && !idx_at_end;

      // Stage 1: accept sample, capture frame-end flag.
      if (accept) begin
        idx_q   <= idx_d;
        last_p1 <= s_last || idx_at_end;
      end
      if (accept)       vld_p1 <= 1'b1;
      else if (advance) vld_p1 <= 1'b0;

      // Stage 2: round, saturate, present downstream; holds while stalled.
      if (advance) begin
        m_valid <= vld_p1;
        if (vld_p1) begin
          m_data <= saturate(rnd_p1);
          m_last <= last_p1;
          if (is_sat(rnd_p1)) sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_stream.sv
module tb_window_stream;

  localparam int SIZE = 8;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int OW   = 16;
  localparam int AW   = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic [CW-1:0]        coef_wdata = '0;
  logic                 cfg_bypass = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic                 s_last = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic signed [OW-1:0] m_data;
  logic                 m_last;
  logic                 frame_err;
  logic                 sat_flag;

  window_stream #(.SIZE(SIZE), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .cfg_bypass(cfg_bypass),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_err(frame_err), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int data;
    bit last;
    bit sat;
    int stamp;
  } ent_t;

  ent_t        q[$];
  int unsigned coefm[SIZE];
  int          idxm;
  bit          fe_m;
  bit          sat_m;
  bit          armed = 0;
  int          n_deliv = 0;
  int          lit_data = 0;
  bit          lit_last = 0;

  // Output = round-half-up(s * c / 2^(CW-1)), clamped to OW bits.
  function automatic int model_out(input int s, input int unsigned c, output bit sat);
    longint p, r;
    p   = longint'(s) * longint'(c);
    r   = (p + (64'sd1 <<< (CW-2))) >>> (CW-1);
    sat = 1'b0;
    if (r > 32767)       begin r = 32767;  sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return int'(r);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      armed = 1;
      q.delete();
      for (int i = 0; i < SIZE; i++) coefm[i] = 32'h8000;
      idxm  = 0;
      fe_m  = 0;
      sat_m = 0;
      chk("rst_m_valid",   m_valid,   0);
      chk("rst_m_data",    m_data,    0);
      chk("rst_m_last",    m_last,    0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_sat_flag",  sat_flag,  0);
    end else if (armed) begin
      bit   exp_valid, exp_ready, acc, sat;
      int   c, d;
      ent_t e;
      exp_valid = (q.size() > 0) && (cyc - q[0].stamp >= 1);
      if (exp_valid && q[0].sat) sat_m = 1;
      exp_ready = (q.size() < 2) || m_ready;
      chk("m_valid",   m_valid,   exp_valid);
      chk("s_ready",   s_ready,   exp_ready);
      chk("frame_err", frame_err, fe_m);
      chk("sat_flag",  sat_flag,  sat_m);
      if (exp_valid) begin
        chk("m_data", m_data, q[0].data);
        chk("m_last", m_last, q[0].last);
        if (m_ready) begin
          lit_data = q[0].data;
          lit_last = q[0].last;
          n_deliv++;
          void'(q.pop_front());
        end
      end
      acc  = s_valid && exp_ready;
      fe_m = 0;
      if (acc) begin
        c       = cfg_bypass ? 32'h8000 : coefm[idxm];
        d       = model_out(int'(s_data), c, sat);
        e.data  = d;
        e.sat   = sat;
        e.last  = s_last || (idxm == SIZE-1);
        e.stamp = cyc + 1;
        q.push_back(e);
        fe_m = s_last && (idxm != SIZE-1);
        idxm = e.last ? 0 : idxm + 1;
      end
      if (coef_we) coefm[coef_addr] = coef_wdata;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int d, input bit last);
    s_valid = 1'b1;
    s_data  = DW'(d);
    s_last  = last;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout got s_ready=0 expected acceptance within 60 cycles");
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL drain_timeout got %0d pending expected 0", q.size());
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = AW'(a);
    coef_wdata = CW'(v);
    @(posedge clk); #1;
    coef_we    = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; coef_we = 1'b0; cfg_bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_deliv = 0;
  endtask

  initial begin
    int held;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);
    @(posedge clk); #1;

    // Pass-through with default coefficients, full frame of 8.
    n_deliv = 0;
    for (int i = 0; i < 8; i++) send(1000, 1'b0);
    wait_idle();
    chk("passthru_count", n_deliv,  8);
    chk("passthru_data",  lit_data, 1000);
    chk("passthru_last",  lit_last, 1);

    // Half-scale coefficients: rounding of negative and positive halves.
    for (int i = 0; i < SIZE; i++) wcoef(i, 16'h4000);
    send(-3, 1'b0); wait_idle();
    chk("round_neg", lit_data, -1);
    send(7, 1'b0); wait_idle();
    chk("round_pos", lit_data, 4);

    // Saturation at index 0, sticky afterwards.
    do_reset();
    wcoef(0, 16'hFFFF);
    send(30000, 1'b0); wait_idle();
    chk("sat_data", lit_data, 32767);
    chk("sat_set",  sat_flag, 1);
    send(100, 1'b0); wait_idle();
    chk("sat_sticky_data", lit_data, 100);
    chk("sat_sticky",      sat_flag, 1);

    // Back-pressure: m_ready low for 5 cycles while 4 samples are offered.
    n_deliv = 0;
    m_ready = 1'b0;
    fork
      begin
        send(11, 1'b0); send(22, 1'b0); send(33, 1'b0); send(44, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_s_ready", s_ready, 0);
        held = int'(m_data);
        chk("stall_first", held, 11);
        repeat (2) @(negedge clk);
        chk("stall_hold", m_data, held);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_idle();
    chk("stall_count", n_deliv,  4);
    chk("stall_order", lit_data, 44);

    // Early frame end at index 3.
    do_reset();
    wcoef(0, 16'h4000);
    send(10, 1'b0); send(20, 1'b0); send(30, 1'b0); send(40, 1'b1);
    @(negedge clk);
    chk("frame_err_pulse", frame_err, 1);
    @(negedge clk);
    chk("frame_err_once", frame_err, 0);
    @(posedge clk); #1;
    send(100, 1'b0); wait_idle();
    chk("after_short_coef0", lit_data, 50);

    // Reset mid-frame with output pending.
    for (int i = 0; i < 4; i++) send(5, 1'b0);
    wait_idle();
    m_ready = 1'b0;
    send(5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_m_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_m_valid", m_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    send(1000, 1'b0); wait_idle();
    chk("post_rst_coef0", lit_data, 1000);

    // Randomized traffic with coefficient writes, bypass and early s_last.
    for (int i = 0; i < 3000; i++) begin
      s_valid    = ($urandom_range(3) != 0);
      s_data     = DW'($urandom);
      s_last     = ($urandom_range(9) == 0);
      m_ready    = ($urandom_range(2) != 0);
      cfg_bypass = ($urandom_range(7) == 0);
      coef_we    = ($urandom_range(5) == 0);
      coef_addr  = AW'($urandom);
      coef_wdata = ($urandom_range(3) == 0) ? CW'(16'hFFFF - $urandom_range(255)) : CW'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0; coef_we = 1'b0; cfg_bypass = 1'b0; m_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_stream.md
WINDOW_STREAM -- requirements
Module: window_stream

Interface
REQ-001 SHALL have parameter SIZE, default 8, frame length in samples (power of two not required, SIZE >= 2).
REQ-002 SHALL have parameter DW, default 16, signed input sample width.
REQ-003 SHALL have parameter CW, default 16, unsigned coefficient width, format Q1.(CW-1), so 1.0 = 2^(CW-1).
REQ-004 SHALL have parameter OW, default 16, signed output sample width; AW = clog2(SIZE) derived.
REQ-005 SHALL use one clock; reset is asynchronous and active-high. Ports clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 coef_we  input  1  coefficient table write strobe.
REQ-009 coef_addr  input  AW  coefficient index to write.
REQ-010 coef_wdata  input  CW  coefficient value.
REQ-011 cfg_bypass  input  1  1 = treat coefficient as 1.0 for the accepted sample.
REQ-012 s_valid  input  1;  s_ready  output  1;  s_data  input  DW;  s_last  input  1 (upstream end-of-frame).
REQ-013 m_valid  output  1;  m_ready  input  1;  m_data  output  OW;  m_last  output  1.
REQ-014 frame_err  output  1  one-cycle pulse on a short frame; sat_flag  output  1  sticky saturation indicator.

Function
REQ-015 SHALL hold a SIZE x CW coefficient register table; a coef_we write SHALL take effect on the next clock edge.
REQ-016 Write and read of the same index in the same cycle SHALL use the old value (read-before-write).
REQ-017 SHALL accept a sample when s_valid && s_ready.
REQ-018 s_ready SHALL be (!stage-1 valid || advance), where advance = !m_valid || m_ready.
REQ-019 An internal index counter (0..SIZE-1) SHALL select coefficient coef[index] for each accepted sample.
REQ-020 The index SHALL then increment, wrapping SIZE-1 -> 0.
REQ-021 The pipeline SHALL have two stages.
REQ-022 Stage 1 SHALL register product P = s_data (signed) x coefficient (zero-extended), width DW+CW+1.
REQ-023 Stage 1 SHALL also register the last flag.
REQ-024 Stage 2 SHALL compute R = (P + 2^(CW-2)) >>> (CW-1), arithmetic shift with round-half-up.
REQ-025 Stage 2 SHALL saturate R to the signed OW range and register it into m_data.
REQ-026 Latency SHALL be exactly 2 cycles from acceptance to m_valid when m_ready stays high; throughput 1 sample/cycle.
REQ-027 When m_valid && !m_ready, m_data, m_last and the pipeline SHALL hold unchanged and no sample SHALL be lost or duplicated.
REQ-028 m_last SHALL be 1 for a sample whose index was SIZE-1 or which arrived with s_last=1.
REQ-029 If s_last=1 is accepted at index != SIZE-1, the index SHALL reset to 0.
REQ-030 In that case frame_err SHALL pulse for one cycle coincident with acceptance.
REQ-031 s_last at index SHALL be SIZE-1 is normal and raises no error.
REQ-032 If saturation occurs, sat_flag SHALL set in the cycle the saturated value is registered.
REQ-033 sat_flag SHALL clear only on rst.
REQ-034 cfg_bypass SHALL substitute 2^(CW-1) for the table coefficient.
REQ-035 cfg_bypass SHALL NOT advance or alter index semantics.

Reset
REQ-036 On rst, all of the following SHALL clear asynchronously: m_valid, m_data, m_last, frame_err, sat_flag, stage-1 valid and index.
REQ-037 On rst, all coefficients SHALL reset to 2^(CW-1) (1.0), giving pass-through behaviour.
REQ-038 s_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-039 Reset mid-frame SHALL discard in-flight samples, and the next accepted sample SHALL use coef[0].

Verification
REQ-040 Scenario: rst release, no writes, s_data=1000 x8, m_ready=1 -> m_data=1000 on each, first two cycles after first accept, m_last on 8th.
REQ-041 Scenario: all coef=0x4000, s_data=-3 -> m_data=-1 (round-half-up of -1.5).
REQ-042 Scenario: s_data=7 -> m_data=4.
REQ-043 Scenario: coef[0]=0xFFFF, s_data=30000 at index 0 -> m_data=32767, sat_flag=1 and stays 1.
REQ-044 Scenario: 4 samples in flight, m_ready low 5 cycles -> s_ready drops, m_data held, all 4 delivered in order after m_ready rises.
REQ-045 Scenario: s_last with 4th sample (index 3) -> that output has m_last=1, frame_err pulses once, 5th sample uses coef[0].
REQ-046 Scenario: rst asserted with index=5 and m_valid=1 -> m_valid=0 immediately, coefficients return to 0x8000, next sample index 0.
